// File: rtl/exmem_wb_pkg.sv
// Shared types for the EX/MEM -> write-back stage: field widths, FSM encoding, ppp codes.
// Bit vectors keep the pipeline's big-endian [0:N-1] numbering.
package exmem_wb_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int PPP_W  = 3;

    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:REG_W-1]  reg_t;
    typedef logic [0:PPP_W-1]  ppp_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    // Register-file write-back field selects (carried through this stage untouched)
    localparam ppp_t PPP_DWORD = 3'b000;
    localparam ppp_t PPP_HI32  = 3'b001;
    localparam ppp_t PPP_LO32  = 3'b010;
    localparam ppp_t PPP_EVEN  = 3'b011;
    localparam ppp_t PPP_ODD   = 3'b100;

    function automatic logic is_load(input logic valid, input logic mem_en, input logic wmem_en);
        return valid & mem_en & ~wmem_en;
    endfunction

endpackage

// File: rtl/exmem_wb_if.sv
// EX/MEM slot, data-memory return and write-back bundle of the exmem_wb stage.
// slave = the stage itself; master = whoever drives the slot and memory (upstream/bench).
interface exmem_wb_if;
    import exmem_wb_pkg::*;

    logic  EXMEM_valid;
    data_t EXMEM_alu_out;
    reg_t  EXMEM_Wreg;
    logic  EXMEM_Wreg_en;
    logic  EXMEM_mem_en;
    logic  EXMEM_Wmem_en;
    ppp_t  EXMEM_ppp;
    logic  flush;
    data_t dmem_dout;
    logic  dmem_ready;
    logic  stall;
    logic  WB_valid;
    data_t WB_data;
    reg_t  WB_Wreg;
    logic  WB_Wreg_en;
    ppp_t  WB_ppp;
    logic  WB_err;

    modport slave (
        input  EXMEM_valid, EXMEM_alu_out, EXMEM_Wreg, EXMEM_Wreg_en,
               EXMEM_mem_en, EXMEM_Wmem_en, EXMEM_ppp, flush, dmem_dout, dmem_ready,
        output stall, WB_valid, WB_data, WB_Wreg, WB_Wreg_en, WB_ppp, WB_err
    );

    modport master (
        output EXMEM_valid, EXMEM_alu_out, EXMEM_Wreg, EXMEM_Wreg_en,
               EXMEM_mem_en, EXMEM_Wmem_en, EXMEM_ppp, flush, dmem_dout, dmem_ready,
        input  stall, WB_valid, WB_data, WB_Wreg, WB_Wreg_en, WB_ppp, WB_err
    );

endinterface

// File: rtl/exmem_wb.sv
// EX/MEM -> WB stage register: ALU/store retire 1 cycle after input, loads 1 cycle after dmem_ready.
// stall is combinational while a load waits; EXMEM_WB_TIMEOUT_EN adds a load-abort wait counter.
module exmem_wb
    import exmem_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic       clk,
    input logic       rst,
    exmem_wb_if.slave bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("exmem_wb: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t r_state;
    logic   r_wb_valid;
    data_t  r_wb_data;
    reg_t   r_wb_wreg;
    logic   r_wb_wreg_en;
    ppp_t   r_wb_ppp;
    reg_t   r_hold_wreg;
    logic   r_hold_wreg_en;
    ppp_t   r_hold_ppp;

    logic   w_is_load;
    logic   w_is_store;
    logic   w_tmo_hit;
    logic   w_stall;

    assign w_is_load  = is_load(bus.EXMEM_valid, bus.EXMEM_mem_en, bus.EXMEM_Wmem_en);
    assign w_is_store = bus.EXMEM_valid & bus.EXMEM_mem_en & bus.EXMEM_Wmem_en;

`ifdef EXMEM_WB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_wb_err;
    assign w_tmo_hit  = (r_state == WAIT_MEM) & ~bus.dmem_ready
                      & (r_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign bus.WB_err = r_wb_err;
`else
    assign w_tmo_hit  = 1'b0;
    assign bus.WB_err = 1'b0;
`endif

    // Reset gating keeps stall low during reset even with a load still on the inputs
    always_comb begin
        w_stall = 1'b0;
        if (rst && !bus.flush) begin
            case (r_state)
                IDLE:     w_stall = w_is_load & ~bus.dmem_ready;
                WAIT_MEM: w_stall = ~bus.dmem_ready & ~w_tmo_hit;
                default:  w_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_wb_wreg      <= '0;
            r_wb_wreg_en   <= 1'b0;
            r_wb_ppp       <= '0;
            r_hold_wreg    <= '0;
            r_hold_wreg_en <= 1'b0;
            r_hold_ppp     <= '0;
`ifdef EXMEM_WB_TIMEOUT_EN
            r_cnt          <= '0;
            r_wb_err       <= 1'b0;
`endif
        end else begin
            r_wb_valid   <= 1'b0;
            r_wb_wreg_en <= 1'b0;
`ifdef EXMEM_WB_TIMEOUT_EN
            r_wb_err     <= 1'b0;
`endif
            if (bus.flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.EXMEM_valid) begin
                            if (!w_is_load || bus.dmem_ready) begin
                                r_wb_valid   <= 1'b1;
                                r_wb_data    <= w_is_load ? bus.dmem_dout : bus.EXMEM_alu_out;
                                r_wb_wreg    <= bus.EXMEM_Wreg;
                                r_wb_wreg_en <= bus.EXMEM_Wreg_en & ~w_is_store;
                                r_wb_ppp     <= bus.EXMEM_ppp;
                            end else begin
                                r_state        <= WAIT_MEM;
                                r_hold_wreg    <= bus.EXMEM_Wreg;
                                r_hold_wreg_en <= bus.EXMEM_Wreg_en;
                                r_hold_ppp     <= bus.EXMEM_ppp;
`ifdef EXMEM_WB_TIMEOUT_EN
                                r_cnt          <= '0;
`endif
                            end
                        end
                    end
                    WAIT_MEM: begin
                        if (bus.dmem_ready) begin
                            r_state      <= IDLE;
                            r_wb_valid   <= 1'b1;
                            r_wb_data    <= bus.dmem_dout;
                            r_wb_wreg    <= r_hold_wreg;
                            r_wb_wreg_en <= r_hold_wreg_en;
                            r_wb_ppp     <= r_hold_ppp;
                        end
`ifdef EXMEM_WB_TIMEOUT_EN
                        // Aborted load still retires so the pipeline sees it, but never writes
                        else if (w_tmo_hit) begin
                            r_state   <= IDLE;
                            r_wb_valid <= 1'b1;
                            r_wb_wreg <= r_hold_wreg;
                            r_wb_ppp  <= r_hold_ppp;
                            r_wb_err  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall      = w_stall;
    assign bus.WB_valid   = r_wb_valid;
    assign bus.WB_data    = r_wb_data;
    assign bus.WB_Wreg    = r_wb_wreg;
    assign bus.WB_Wreg_en = r_wb_wreg_en;
    assign bus.WB_ppp     = r_wb_ppp;

endmodule

// File: tb/tb_exmem_wb.sv
// Bench for exmem_wb: directed scenarios plus random instruction stream checked against a
// transaction-level model (each instruction retires once, loads after a chosen memory delay).
module tb_exmem_wb;
    import exmem_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exmem_wb_if bus();

    exmem_wb #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.EXMEM_valid   = 1'b0;
        bus.EXMEM_alu_out = '0;
        bus.EXMEM_Wreg    = '0;
        bus.EXMEM_Wreg_en = 1'b0;
        bus.EXMEM_mem_en  = 1'b0;
        bus.EXMEM_Wmem_en = 1'b0;
        bus.EXMEM_ppp     = '0;
        bus.flush         = 1'b0;
        bus.dmem_dout     = '0;
        bus.dmem_ready    = 1'b0;
    endtask

    task automatic put(input logic v, input logic mem, input logic wmem, input logic wen,
                       input logic [4:0] wreg, input logic [63:0] alu, input logic [2:0] ppp);
        bus.EXMEM_valid   = v;
        bus.EXMEM_mem_en  = mem;
        bus.EXMEM_Wmem_en = wmem;
        bus.EXMEM_Wreg_en = wen;
        bus.EXMEM_Wreg    = wreg;
        bus.EXMEM_alu_out = alu;
        bus.EXMEM_ppp     = ppp;
    endtask

    task automatic stall_is(input string tag, input logic exp);
        #1;
        chk(tag, bus.stall, exp);
    endtask

    task automatic expect_retire(input string tag, input logic [63:0] data, input logic [4:0] wreg,
                                 input logic wen, input logic [2:0] ppp);
        chk({tag, ".valid"}, bus.WB_valid, 1'b1);
        chk({tag, ".data"},  bus.WB_data, data);
        chk({tag, ".wreg"},  bus.WB_Wreg, wreg);
        chk({tag, ".wen"},   bus.WB_Wreg_en, wen);
        chk({tag, ".ppp"},   bus.WB_ppp, ppp);
        chk({tag, ".err"},   bus.WB_err, 1'b0);
        last_data = data;
    endtask

    task automatic expect_bubble(input string tag);
        chk({tag, ".valid"}, bus.WB_valid, 1'b0);
        chk({tag, ".wen"},   bus.WB_Wreg_en, 1'b0);
        chk({tag, ".data"},  bus.WB_data, last_data);
        chk({tag, ".err"},   bus.WB_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] val;
        logic [4:0]  wreg;
        logic [2:0]  ppp;
        logic        wen;
        int          kind;
        int          d;

        // Reset state
        idle_in();
        #12;
        chk("rst.valid", bus.WB_valid, 1'b0);
        chk("rst.data",  bus.WB_data, 64'h0);
        chk("rst.wreg",  bus.WB_Wreg, 5'd0);
        chk("rst.wen",   bus.WB_Wreg_en, 1'b0);
        chk("rst.ppp",   bus.WB_ppp, 3'd0);
        chk("rst.err",   bus.WB_err, 1'b0);
        chk("rst.stall", bus.stall, 1'b0);
        cyc();
        rst = 1'b1;

        // Back-to-back ALU ops: one retirement per cycle, no stall
        for (int i = 1; i <= 3; i++) begin
            put(1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 64'h100 + 64'(i), 3'(i));
            stall_is("b2b.stall", 1'b0);
            cyc();
            expect_retire("b2b", 64'h100 + 64'(i), 5'(i), 1'b1, 3'(i));
        end

        // Load with 3 wait cycles
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 64'h40, PPP_LO32);
        for (int k = 0; k < 3; k++) begin
            stall_is("ld3.stall", 1'b1);
            cyc();
            expect_bubble("ld3.wait");
        end
        bus.dmem_ready = 1'b1;
        bus.dmem_dout  = 64'hDEAD_BEEF;
        stall_is("ld3.rdy_stall", 1'b0);
        cyc();
        expect_retire("ld3", 64'hDEAD_BEEF, 5'd7, 1'b1, PPP_LO32);
        bus.dmem_ready = 1'b0;

        // Store with Wreg_en set: retires without a register write
        put(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 64'h80, PPP_DWORD);
        stall_is("st.stall", 1'b0);
        cyc();
        expect_retire("st", 64'h80, 5'd5, 1'b0, PPP_DWORD);

        // flush together with dmem_ready during WAIT_MEM
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 64'h90, PPP_HI32);
        stall_is("fl.stall0", 1'b1);
        cyc();
        expect_bubble("fl.wait");
        stall_is("fl.stall1", 1'b1);
        bus.dmem_ready = 1'b1;
        bus.dmem_dout  = 64'h1234_5678;
        bus.flush      = 1'b1;
        stall_is("fl.stall_drop", 1'b0);
        cyc();
        expect_bubble("fl.bubble");
        bus.flush = 1'b0;
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 64'hA5, PPP_EVEN);
        stall_is("fl.alu_stall", 1'b0);
        cyc();
        expect_retire("fl.alu", 64'hA5, 5'd6, 1'b1, PPP_EVEN);
        bus.dmem_ready = 1'b0;

`ifdef EXMEM_WB_TIMEOUT_EN
        // Load abort after TIMEOUT_CYCLES=4 stall cycles
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'hB0, PPP_ODD);
        for (int k = 0; k < 4; k++) begin
            stall_is("tmo.stall", 1'b1);
            cyc();
            expect_bubble("tmo.wait");
        end
        stall_is("tmo.stall_drop", 1'b0);
        cyc();
        chk("tmo.valid", bus.WB_valid, 1'b1);
        chk("tmo.wen",   bus.WB_Wreg_en, 1'b0);
        chk("tmo.err",   bus.WB_err, 1'b1);
        chk("tmo.data",  bus.WB_data, last_data);
        idle_in();
        cyc();
        expect_bubble("tmo.after");
`else
        // Without the timeout a load waits indefinitely
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'hB0, PPP_ODD);
        for (int k = 0; k < 20; k++) begin
            stall_is("nto.stall", 1'b1);
            cyc();
            expect_bubble("nto.wait");
        end
        bus.dmem_ready = 1'b1;
        bus.dmem_dout  = 64'hFEED_F00D_0000_0001;
        stall_is("nto.rdy_stall", 1'b0);
        cyc();
        expect_retire("nto", 64'hFEED_F00D_0000_0001, 5'd9, 1'b1, PPP_ODD);
        idle_in();
`endif

        // Reset while a load is pending
        put(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 64'hC0, PPP_HI32);
        stall_is("rw.stall0", 1'b1);
        cyc();
        stall_is("rw.stall1", 1'b1);
        rst = 1'b0;
        #1;
        chk("rw.stall", bus.stall, 1'b0);
        chk("rw.valid", bus.WB_valid, 1'b0);
        chk("rw.data",  bus.WB_data, 64'h0);
        chk("rw.wreg",  bus.WB_Wreg, 5'd0);
        chk("rw.wen",   bus.WB_Wreg_en, 1'b0);
        chk("rw.ppp",   bus.WB_ppp, 3'd0);
        chk("rw.err",   bus.WB_err, 1'b0);
        last_data = '0;
        cyc();
        rst = 1'b1;
        put(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 64'h1, PPP_DWORD);
        stall_is("rw.alu_stall", 1'b0);
        cyc();
        expect_retire("rw.alu", 64'h1, 5'd3, 1'b1, PPP_DWORD);

        // Random instruction stream: every instruction retires exactly once, loads after d waits
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            wreg = 5'($urandom);
            ppp  = 3'($urandom);
            wen  = 1'($urandom);
            val  = {$urandom, $urandom};
            bus.dmem_dout  = {$urandom, $urandom};
            bus.dmem_ready = 1'($urandom);
            case (kind)
                0: begin
                    put(1'b0, 1'($urandom), 1'($urandom), wen, wreg, val, ppp);
                    stall_is("rnd.nop_stall", 1'b0);
                    cyc();
                    expect_bubble("rnd.nop");
                end
                1: begin
                    put(1'b1, 1'b0, 1'($urandom), wen, wreg, val, ppp);
                    stall_is("rnd.alu_stall", 1'b0);
                    cyc();
                    expect_retire("rnd.alu", val, wreg, wen, ppp);
                end
                2: begin
                    put(1'b1, 1'b1, 1'b1, wen, wreg, val, ppp);
                    stall_is("rnd.st_stall", 1'b0);
                    cyc();
                    expect_retire("rnd.st", val, wreg, 1'b0, ppp);
                end
                default: begin
                    d = $urandom_range(0, 3);
                    put(1'b1, 1'b1, 1'b0, wen, wreg, {$urandom, $urandom}, ppp);
                    for (int k = 0; k < d; k++) begin
                        bus.dmem_ready = 1'b0;
                        bus.dmem_dout  = {$urandom, $urandom};
                        stall_is("rnd.ld_stall", 1'b1);
                        cyc();
                        expect_bubble("rnd.ld_wait");
                    end
                    bus.dmem_ready = 1'b1;
                    bus.dmem_dout  = val;
                    stall_is("rnd.ld_rdy_stall", 1'b0);
                    cyc();
                    expect_retire("rnd.ld", val, wreg, wen, ppp);
                end
            endcase
        end

        idle_in();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exmem_wb.md
# exmem_wb

Pipeline stage register at the consuming end of the EX/MEM stage. Accepts one EX/MEM result per cycle (ALU result, or store, or load), waits for data-memory read data on loads, stalls the upstream stages while a load is outstanding, and presents an aligned write-back bundle to the register file and the forwarding logic. A bubble (all enables low) is emitted in every cycle with no retiring instruction.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles for a load before abort; used only when EXMEM_WB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-low
- EXMEM_valid  input  1  EX/MEM slot holds a real instruction
- EXMEM_alu_out  input  [0:63]  ALU result
- EXMEM_Wreg  input  [0:4]  destination register address
- EXMEM_Wreg_en  input  1  instruction writes the register file
- EXMEM_mem_en  input  1  memory instruction
- EXMEM_Wmem_en  input  1  memory write (store) when mem_en=1
- EXMEM_ppp  input  [0:2]  write-back bit-field select, passed through
- flush  input  1  synchronous kill of the EX/MEM slot and any pending load
- dmem_dout  input  [0:63]  data-memory read data
- dmem_ready  input  1  dmem_dout valid this cycle
- stall  output  1  combinational; upstream holds all EXMEM_* inputs while high
- WB_valid  output  1  one instruction retires this cycle
- WB_data  output  [0:63]  write-back data
- WB_Wreg  output  [0:4]  write-back register address
- WB_Wreg_en  output  1  register-file write enable
- WB_ppp  output  [0:2]  write-back bit-field select
- WB_err  output  1  load aborted by timeout (one-cycle pulse)

## Operation
- Classification of a valid slot: load = mem_en & ~Wmem_en; store = mem_en & Wmem_en; ALU = ~mem_en.
- FSM states: IDLE, WAIT_MEM.
- IDLE, ALU op: capture alu_out, Wreg, Wreg_en, ppp; WB_valid=1 on the next cycle.
- IDLE, store: retire on the next cycle with WB_valid=1 and WB_Wreg_en forced to 0. No wait for dmem.
- IDLE, load, dmem_ready=1 in the same cycle: capture dmem_dout; no stall; no state change.
- IDLE, load, dmem_ready=0: stall=1; go to WAIT_MEM; register outputs take a bubble.
- WAIT_MEM: stall = ~dmem_ready. When dmem_ready=1, capture dmem_dout with the held Wreg, Wreg_en, and ppp, then return to IDLE.
- EXMEM_valid=0: bubble. WB_valid=0, WB_Wreg_en=0, WB_data holds its previous value.
- flush: has priority over dmem_ready and over the timeout. It produces a bubble on the next cycle, sends the FSM to IDLE, and drops stall in the same cycle.
- Bubbles always force WB_Wreg_en=0. WB_Wreg_en=1 only when WB_valid=1.

## Timing
- Reset (rst low, asynchronous): state=IDLE; WB_valid, WB_data, WB_Wreg, WB_Wreg_en, WB_ppp, and WB_err all 0; the wait counter is 0. stall is 0 while in reset.
- ALU and store latency: 1 cycle, from the input cycle to the WB_valid cycle.
- Load latency: 1 cycle after the cycle in which dmem_ready is sampled high.
- Stall cycles for a load: equal to the number of cycles before dmem_ready, counted from the first load cycle.
- dmem_ready outside a load (IDLE, no load; or after a flush): ignored.
- Throughput: 1 instruction per cycle when there are no load waits.

## Configuration
- EXMEM_WB_TIMEOUT_EN defined:
  - 8-bit wait counter cleared on entry to WAIT_MEM and incremented each WAIT_MEM cycle with dmem_ready=0.
  - On the cycle the counter equals TIMEOUT_CYCLES-1 with dmem_ready still 0: stall drops and the FSM goes to IDLE.
  - The next cycle retires with WB_valid=1, WB_Wreg_en=0, WB_err=1.
- EXMEM_WB_TIMEOUT_EN undefined: no counter; WAIT_MEM lasts indefinitely; WB_err is tied to 0.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, WAIT_MEM=1'b1);
  - field widths: data 64, register address 5, ppp 3;
  - the ppp encodings used by the register-file write-back.
- Single module; no sub-module needed.

## Test plan
- Reset mid-WAIT_MEM: load pending, rst low → all outputs 0 and stall=0 immediately; after release, an ALU op with alu_out=64'h1 and Wreg=3 retires with WB_data=64'h1, WB_Wreg=3.
- Back-to-back ALU ops with Wreg=1, 2, 3 → WB_valid high for 3 consecutive cycles, WB_Wreg=1, 2, 3 in order; stall never asserted.
- Load Wreg=7, dmem_ready after 3 cycles with dout=64'hDEAD_BEEF → stall high for exactly 3 cycles; WB_data=64'hDEAD_BEEF, WB_Wreg=7, WB_Wreg_en=1 one cycle after ready.
- Store with Wreg_en=1 → WB_valid=1 and WB_Wreg_en=0 on the next cycle; no stall.
- flush in the same cycle as dmem_ready during WAIT_MEM → next cycle WB_valid=0, state IDLE; a following ALU op retires normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4, dmem_ready never high) → stall high for 4 cycles, then WB_err=1, WB_valid=1, WB_Wreg_en=0 for exactly one cycle.
